// File: rtl/systolic_feeder_if.sv
// Handshake and data bus between a matrix source and the 3x3 systolic feeder.
// Optional stall input exists only when SYSTOLIC_FEEDER_STALL_EN is defined.
interface systolic_feeder_if #(
    parameter int DW = 8
);
    logic            start;
    logic [9*DW-1:0] a_mat;
    logic [9*DW-1:0] b_mat;
`ifdef SYSTOLIC_FEEDER_STALL_EN
    logic            stall;
`endif
    logic            ready;
    logic            clr_acc;
    logic            valid;
    logic            done;
    logic [DW-1:0]   a_out0, a_out1, a_out2;
    logic [DW-1:0]   b_out0, b_out1, b_out2;

    modport master (
`ifdef SYSTOLIC_FEEDER_STALL_EN
        output stall,
`endif
        output start, a_mat, b_mat,
        input  ready, clr_acc, valid, done,
        input  a_out0, a_out1, a_out2, b_out0, b_out1, b_out2
    );

    modport slave (
`ifdef SYSTOLIC_FEEDER_STALL_EN
        input  stall,
`endif
        input  start, a_mat, b_mat,
        output ready, clr_acc, valid, done,
        output a_out0, a_out1, a_out2, b_out0, b_out1, b_out2
    );
endinterface

// File: rtl/systolic_feeder.sv
// Streams a latched 3x3 matrix pair into a systolic MAC array with diagonal skew.
// Define SYSTOLIC_FEEDER_STALL_EN to add a stall input that freezes FEED/DRAIN.
module systolic_feeder #(
    parameter int DW    = 8,
    parameter int DRAIN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    systolic_feeder_if.slave   bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FEED, S_DRAIN, S_DONE} state_t;

    state_t          state;
    logic [2:0]      t;
    logic [3:0]      dcnt;
    logic [9*DW-1:0] a_lat;
    logic [9*DW-1:0] b_lat;
    logic            ready_p0;
    logic            clr_p0;
    logic            vld_p0;
    logic            done_p0;
    logic [DW-1:0]   a_p0 [3];
    logic [DW-1:0]   b_p0 [3];
    logic            stall_i;

`ifdef SYSTOLIC_FEEDER_STALL_EN
    assign stall_i = bus.stall;
`else
    assign stall_i = 1'b0;
`endif

    // Row i enters the array i cycles late, so slot t carries A[i][t-i].
    function automatic logic [DW-1:0] a_elem(input logic [9*DW-1:0] m, input int i, input int ts);
        int k;
        k = ts - i;
        if (k >= 0 && k <= 2) return m[(3*i + k)*DW +: DW];
        return '0;
    endfunction

    function automatic logic [DW-1:0] b_elem(input logic [9*DW-1:0] m, input int j, input int ts);
        int k;
        k = ts - j;
        if (k >= 0 && k <= 2) return m[(3*k + j)*DW +: DW];
        return '0;
    endfunction

    // Outputs are computed from the state being entered, so they show up registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            t        <= '0;
            dcnt     <= '0;
            a_lat    <= '0;
            b_lat    <= '0;
            ready_p0 <= 1'b1;
            clr_p0   <= 1'b0;
            vld_p0   <= 1'b0;
            done_p0  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_p0[i] <= '0;
                b_p0[i] <= '0;
            end
        end else begin
            clr_p0  <= 1'b0;
            vld_p0  <= 1'b0;
            done_p0 <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                a_p0[i] <= '0;
                b_p0[i] <= '0;
            end
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state    <= S_LOAD;
                        a_lat    <= bus.a_mat;
                        b_lat    <= bus.b_mat;
                        ready_p0 <= 1'b0;
                        clr_p0   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    state  <= S_FEED;
                    t      <= '0;
                    dcnt   <= '0;
                    vld_p0 <= 1'b1;
                    for (int i = 0; i < 3; i++) begin
                        a_p0[i] <= a_elem(a_lat, i, 0);
                        b_p0[i] <= b_elem(b_lat, i, 0);
                    end
                end
                S_FEED: begin
                    // A stalled edge emits a bubble and holds t; the next slot follows later.
                    if (!stall_i) begin
                        if (t == 3'd4) begin
                            state <= S_DRAIN;
                            dcnt  <= '0;
                        end else begin
                            t      <= t + 3'd1;
                            vld_p0 <= 1'b1;
                            for (int i = 0; i < 3; i++) begin
                                a_p0[i] <= a_elem(a_lat, i, int'(t) + 1);
                                b_p0[i] <= b_elem(b_lat, i, int'(t) + 1);
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (!stall_i) begin
                        if (dcnt == 4'(DRAIN - 1)) begin
                            state   <= S_DONE;
                            done_p0 <= 1'b1;
                        end else begin
                            dcnt <= dcnt + 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    ready_p0 <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.ready   = ready_p0;
    assign bus.clr_acc = clr_p0;
    assign bus.valid   = vld_p0;
    assign bus.done    = done_p0;
    assign bus.a_out0  = a_p0[0];
    assign bus.a_out1  = a_p0[1];
    assign bus.a_out2  = a_p0[2];
    assign bus.b_out0  = b_p0[0];
    assign bus.b_out1  = b_p0[1];
    assign bus.b_out2  = b_p0[2];
endmodule
